// File: rtl/fifo_drain_stage_if.sv
// Bundle for fifo_drain_stage: FIFO read side, flush, the output stream and
// occupancy. The 'master' modport is the drain stage's view and the 'slave'
// modport is the environment's view (FIFO plus consumer).
// The optional statistics outputs are present only when FIFO_DRAIN_STATS_EN
// is defined.
interface fifo_drain_stage_if #(
    parameter int WIDTH = 8
);
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_rdata;
    logic             fifo_read;
    logic             flush;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic [1:0]       buf_count;
`ifdef FIFO_DRAIN_STATS_EN
    logic [15:0]      word_count;
    logic [15:0]      frame_count;
`endif

    modport master (
        input  fifo_empty,
        input  fifo_rdata,
        input  flush,
        input  out_ready,
        output fifo_read,
        output out_data,
        output out_valid,
        output out_last,
        output buf_count
`ifdef FIFO_DRAIN_STATS_EN
        ,
        output word_count,
        output frame_count
`endif
    );

    modport slave (
        output fifo_empty,
        output fifo_rdata,
        output flush,
        output out_ready,
        input  fifo_read,
        input  out_data,
        input  out_valid,
        input  out_last,
        input  buf_count
`ifdef FIFO_DRAIN_STATS_EN
        ,
        input  word_count,
        input  frame_count
`endif
    );
endinterface

// File: rtl/fifo_drain_stage.sv
// fifo_drain_stage: read-side stage placed right after a FIFO controller.
// Issues single-cycle read strobes while the FIFO is non-empty and the local
// 2-entry skid buffer has room, and presents buffered words on a valid/ready
// stream grouped into FRAME_LEN-word frames (out_last on the final word).
//
// The read strobe is a function of registered occupancy and fifo_empty only,
// so there is no combinational path from out_ready back to the FIFO. The cost
// is that a full buffer does not refill in the cycle it pops; sustained
// throughput of one word per cycle is still reached because a single-entry
// buffer can push and pop together.
//
// Optional feature macro: FIFO_DRAIN_STATS_EN adds saturating 16-bit
// word_count / frame_count outputs, cleared by reset only.
module fifo_drain_stage #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    fifo_drain_stage_if.master    bus
);

    // Beat counter is at least one bit so FRAME_LEN=1 still elaborates.
    localparam int              BEAT_W   = (FRAME_LEN <= 1) ? 1 : $clog2(FRAME_LEN);
    localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(FRAME_LEN - 1);
    localparam logic [BEAT_W-1:0] BEAT_ONE = BEAT_W'(1);
    localparam logic [BEAT_W-1:0] BEAT_ZERO = BEAT_W'(0);

    // Registered state; slot0_r is the head and drives out_data directly.
    logic [WIDTH-1:0]  slot0_r;
    logic [WIDTH-1:0]  slot1_r;
    logic [1:0]        count_r;
    logic [BEAT_W-1:0] beat_r;
    logic              out_valid_r;
    logic              out_last_r;

    // Next-state values.
    logic              fifo_read_s;
    logic              pop_s;
    logic [WIDTH-1:0]  slot0_s;
    logic [WIDTH-1:0]  slot1_s;
    logic [1:0]        count_s;
    logic [BEAT_W-1:0] beat_s;
    logic              out_valid_s;
    logic              out_last_s;

    // Read strobe, accepted pop, and next buffer/frame state.
    always_comb begin
        fifo_read_s = ~reset & ~bus.flush & ~bus.fifo_empty & (count_r != 2'd2);
        // A handshake in a flush cycle does not count as a pop.
        pop_s       = out_valid_r & bus.out_ready & ~bus.flush;

        slot0_s = slot0_r;
        slot1_s = slot1_r;
        count_s = count_r;
        beat_s  = beat_r;

        if (bus.flush) begin
            count_s = 2'd0;
            beat_s  = BEAT_ZERO;
        end else begin
            case ({fifo_read_s, pop_s})
                2'b10: begin
                    // Push only: fill the first free slot.
                    if (count_r == 2'd0) begin
                        slot0_s = bus.fifo_rdata;
                    end else begin
                        slot1_s = bus.fifo_rdata;
                    end
                    count_s = count_r + 2'd1;
                end
                2'b01: begin
                    // Pop only: advance slot1 into the head when it is occupied.
                    if (count_r == 2'd2) begin
                        slot0_s = slot1_r;
                    end else begin
                        slot0_s = slot0_r;
                    end
                    count_s = count_r - 2'd1;
                end
                2'b11: begin
                    // Push and pop: only possible with one word held, so the
                    // new word sits directly behind the departing head.
                    slot0_s = bus.fifo_rdata;
                    count_s = count_r;
                end
                default: begin
                    count_s = count_r;
                end
            endcase

            if (pop_s) begin
                beat_s = (beat_r == BEAT_MAX) ? BEAT_ZERO : (beat_r + BEAT_ONE);
            end else begin
                beat_s = beat_r;
            end
        end

        out_valid_s = (count_s != 2'd0);
        out_last_s  = out_valid_s & (beat_s == BEAT_MAX);
    end

    // Buffer, occupancy, frame position and registered stream flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot0_r     <= {WIDTH{1'b0}};
            slot1_r     <= {WIDTH{1'b0}};
            count_r     <= 2'd0;
            beat_r      <= BEAT_ZERO;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else begin
            slot0_r     <= slot0_s;
            slot1_r     <= slot1_s;
            count_r     <= count_s;
            beat_r      <= beat_s;
            out_valid_r <= out_valid_s;
            out_last_r  <= out_last_s;
        end
    end

    assign bus.fifo_read = fifo_read_s;
    assign bus.out_data  = slot0_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_last  = out_last_r;
    assign bus.buf_count = count_r;

`ifdef FIFO_DRAIN_STATS_EN
    logic [15:0] word_count_r;
    logic [15:0] frame_count_r;

    // Saturating pop and frame counters; flush leaves them untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_count_r  <= 16'h0000;
            frame_count_r <= 16'h0000;
        end else begin
            if (pop_s && (word_count_r != 16'hFFFF)) begin
                word_count_r <= word_count_r + 16'h0001;
            end else begin
                word_count_r <= word_count_r;
            end
            if (pop_s && out_last_r && (frame_count_r != 16'hFFFF)) begin
                frame_count_r <= frame_count_r + 16'h0001;
            end else begin
                frame_count_r <= frame_count_r;
            end
        end
    end

    assign bus.word_count  = word_count_r;
    assign bus.frame_count = frame_count_r;
`endif

endmodule

// File: tb/tb_fifo_drain_stage.sv
// Directed bench for fifo_drain_stage. Stimulus loads a behavioural FIFO
// and pushes hand-computed {data,last} expectations into a queue; a monitor
// pops and compares on every output handshake. Inline checks cover strobes,
// occupancy, reset and flush behaviour.
module tb_fifo_drain_stage;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   strobes;
    logic rd_s;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] fifo_q[$];

    fifo_drain_stage_if #(.WIDTH(8)) ifc ();

    fifo_drain_stage #(.WIDTH(8), .FRAME_LEN(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

`ifdef FIFO_DRAIN_STATS_EN
    fifo_drain_stage_if #(.WIDTH(8)) sif ();

    fifo_drain_stage #(.WIDTH(8), .FRAME_LEN(1)) dut_stat (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic update_fifo();
        ifc.fifo_empty = (fifo_q.size() == 0);
        ifc.fifo_rdata = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
    endtask

    task automatic load(input logic [7:0] d);
        fifo_q.push_back(d);
        update_fifo();
    endtask

    task automatic expect_word(input logic [7:0] d, input logic l);
        exp_t e;
        e.d = d;
        e.l = l;
        exp_q.push_back(e);
    endtask

    // One clock: sample the strobe mid-cycle, then retire the read in the model.
    task automatic tick();
        @(negedge clk);
        rd_s = ifc.fifo_read;
        if (rd_s) strobes++;
        @(posedge clk);
        #1;
        if (rd_s && fifo_q.size() > 0) void'(fifo_q.pop_front());
        update_fifo();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
    endtask

    task automatic release_reset();
        reset   = 1'b0;
        strobes = 0;
    endtask

    task automatic drain(input string name, input int max);
        for (int i = 0; i < max && exp_q.size() != 0; i++) tick();
        chk({name, "_drained"}, exp_q.size(), 0);
        chk({name, "_idle_valid"}, ifc.out_valid, 1'b0);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        strobes = 0;
        rd_s    = 1'b0;
        reset   = 1'b1;
        ifc.flush     = 1'b0;
        ifc.out_ready = 1'b0;
        update_fifo();
`ifdef FIFO_DRAIN_STATS_EN
        sif.flush      = 1'b0;
        sif.out_ready  = 1'b0;
        sif.fifo_empty = 1'b1;
        sif.fifo_rdata = 8'h00;
`endif
        fork
            // Monitor: compare every accepted output word against the scoreboard.
            begin
                forever begin
                    @(negedge clk);
                    if (!reset && !ifc.flush && ifc.out_valid && ifc.out_ready) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_word", {24'h0, ifc.out_data}, 32'hFFFF_FFFF);
                        end else begin
                            exp_t e;
                            e = exp_q.pop_front();
                            chk("out_data", {24'h0, ifc.out_data}, {24'h0, e.d});
                            chk("out_last", ifc.out_last, e.l);
                        end
                    end
                end
            end
            begin
                // Test 1: reset state with a non-empty FIFO, then three words.
                fifo_q.delete();
                load(8'hA1); load(8'hA2); load(8'hA3);
                ifc.out_ready = 1'b1;
                do_reset();
                chk("rst_fifo_read", rd_s, 1'b0);
                chk("rst_buf_count", ifc.buf_count, 2'd0);
                chk("rst_out_valid", ifc.out_valid, 1'b0);
                chk("rst_out_last", ifc.out_last, 1'b0);
                chk("rst_out_data", ifc.out_data, 8'h00);
                expect_word(8'hA1, 1'b0);
                expect_word(8'hA2, 1'b0);
                expect_word(8'hA3, 1'b0);
                release_reset();
                tick();
                chk("t1_first_strobe", rd_s, 1'b1);
                chk("t1_latency_valid", ifc.out_valid, 1'b1);
                chk("t1_latency_data", ifc.out_data, 8'hA1);
                tick();
                chk("t1_strobe2", rd_s, 1'b1);
                tick();
                chk("t1_strobe3", rd_s, 1'b1);
                tick();
                chk("t1_no_strobe_empty", rd_s, 1'b0);
                chk("t1_strobe_count", strobes, 3);
                drain("t1", 20);

                // Test 2: two full frames, last on 13 and 17.
                fifo_q.delete();
                do_reset();
                for (int i = 0; i < 8; i++) begin
                    load(8'h10 + 8'(i));
                    expect_word(8'h10 + 8'(i), (i == 3) || (i == 7));
                end
                release_reset();
                drain("t2", 30);

                // Test 3: stalled consumer fills the buffer with two strobes.
                fifo_q.delete();
                ifc.out_ready = 1'b0;
                do_reset();
                for (int i = 0; i < 6; i++) begin
                    load(8'h30 + 8'(i));
                    expect_word(8'h30 + 8'(i), (i == 3));
                end
                release_reset();
                for (int i = 0; i < 5; i++) tick();
                chk("t3_strobes", strobes, 2);
                chk("t3_buf_full", ifc.buf_count, 2'd2);
                chk("t3_read_blocked", rd_s, 1'b0);
                chk("t3_held_data", ifc.out_data, 8'h30);
                chk("t3_held_last", ifc.out_last, 1'b0);

                // Test 4: pop from a full buffer blocks the read for that cycle.
                ifc.out_ready = 1'b1;
                tick();
                chk("t4_no_read_on_full_pop", rd_s, 1'b0);
                chk("t4_count_after_pop", ifc.buf_count, 2'd1);
                chk("t4_next_head", ifc.out_data, 8'h31);
                tick();
                chk("t4_read_resumes", rd_s, 1'b1);
                chk("t4_count_push_pop", ifc.buf_count, 2'd1);
                drain("t4", 30);

                // Test 5: flush at beat 2 with a full buffer.
                fifo_q.delete();
                do_reset();
                load(8'h20); load(8'h21);
                expect_word(8'h20, 1'b0);
                expect_word(8'h21, 1'b0);
                release_reset();
                drain("t5a", 10);
                ifc.out_ready = 1'b0;
                for (int i = 0; i < 6; i++) load(8'h22 + 8'(i));
                expect_word(8'h24, 1'b0);
                expect_word(8'h25, 1'b0);
                expect_word(8'h26, 1'b0);
                expect_word(8'h27, 1'b1);
                tick(); tick(); tick();
                chk("t5_full_before_flush", ifc.buf_count, 2'd2);
                ifc.flush = 1'b1;
                tick();
                ifc.flush = 1'b0;
                chk("t5_flush_no_strobe", rd_s, 1'b0);
                chk("t5_flush_count", ifc.buf_count, 2'd0);
                chk("t5_flush_valid", ifc.out_valid, 1'b0);
                chk("t5_flush_last", ifc.out_last, 1'b0);
                tick();
                chk("t5_read_after_flush", rd_s, 1'b1);
                chk("t5_head_after_flush", ifc.out_data, 8'h24);
                ifc.out_ready = 1'b1;
                drain("t5b", 20);

                // Flush suppresses the strobe even with room in the buffer.
                load(8'h28);
                ifc.flush = 1'b1;
                tick();
                ifc.flush = 1'b0;
                chk("t5_flush_blocks_read", rd_s, 1'b0);
                chk("t5_flush_empty_count", ifc.buf_count, 2'd0);
                expect_word(8'h28, 1'b0);
                drain("t5c", 10);

`ifdef FIFO_DRAIN_STATS_EN
                // Statistics: saturation, flush immunity, reset clear.
                do_reset();
                sif.fifo_empty = 1'b0;
                sif.fifo_rdata = 8'h5A;
                sif.out_ready  = 1'b1;
                release_reset();
                tick();
                chk("st_last_len1", sif.out_last, 1'b1);
                for (int i = 0; i < 70005; i++) tick();
                chk("st_word_sat", sif.word_count, 16'hFFFF);
                chk("st_frame_sat", sif.frame_count, 16'hFFFF);
                sif.flush = 1'b1;
                tick();
                sif.flush = 1'b0;
                chk("st_flush_word", sif.word_count, 16'hFFFF);
                chk("st_flush_frame", sif.frame_count, 16'hFFFF);
                chk("st_flush_count", sif.buf_count, 2'd0);
                reset = 1'b1;
                tick();
                chk("st_reset_word", sif.word_count, 16'h0000);
                chk("st_reset_frame", sif.frame_count, 16'h0000);
                release_reset();
`endif

                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        join_any
    end

endmodule
